matrix_column_scanner: RTL

- Downstream of the alternate-display column mux; consumes its five 7-bit column images (col_4..col_0) and time-multiplexes them onto the physical 5x7 LED matrix.
- Drives one column at a time at a prescaled rate with a blanking gap between columns to prevent ghosting.
- Snapshots all five columns once per frame, so a selector change mid-frame never tears the image.

---
 rtl/matrix_column_scanner_if.sv | 29 ++
 rtl/matrix_column_scanner.sv | 100 ++++++++++
 2 files changed

// File: rtl/matrix_column_scanner_if.sv
// Bus between the column-image source and the matrix scanner.
//   enable       : scan enable from the source side
//   col_4..col_0 : 7-bit column images (bit k = row k lit)
//   col_drive    : one-hot physical column select (polarity per scanner parameter)
//   row_drive    : row data for the currently selected column
//   frame_start  : one-cycle pulse when a frame snapshot is taken
interface matrix_column_scanner_if;
    logic       enable;
    logic [6:0] col_4;
    logic [6:0] col_3;
    logic [6:0] col_2;
    logic [6:0] col_1;
    logic [6:0] col_0;
    logic [4:0] col_drive;
    logic [6:0] row_drive;
    logic       frame_start;

    // Image source / test driver side
    modport master (
        output enable, col_4, col_3, col_2, col_1, col_0,
        input  col_drive, row_drive, frame_start
    );

    // Scanner side
    modport slave (
        input  enable, col_4, col_3, col_2, col_1, col_0,
        output col_drive, row_drive, frame_start
    );
endinterface

// File: rtl/matrix_column_scanner.sv
// Time-multiplexes five 7-bit column images onto a 5x7 LED matrix.
// One column is driven per slot of CLK_DIV cycles; the first BLANK_CYCLES of
// each slot are blanked to avoid ghosting. All five columns are snapshotted
// once per frame so the image never tears mid-frame.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave modport carrying enable, col_4..col_0 in and
//           col_drive, row_drive, frame_start out (all outputs registered)
module matrix_column_scanner #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter bit          COL_ACTIVE_LOW = 1'b1,
    parameter bit          ROW_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    matrix_column_scanner_if.slave  bus
);

    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned NUM_ROWS = 7;
    localparam int unsigned CNT_W    = $clog2(CLK_DIV);
    localparam int unsigned IDX_W    = 3;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] COL_OFF   = {NUM_COLS{COL_ACTIVE_LOW}};
    localparam logic [NUM_ROWS-1:0] ROW_OFF   = {NUM_ROWS{ROW_ACTIVE_LOW}};

    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]  fb_q, fb_d;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]  img_c;
    logic [NUM_COLS-1:0]                col_drive_q, col_drive_d;
    logic [NUM_ROWS-1:0]                row_drive_q, row_drive_d;
    logic                               frame_start_q, frame_start_d;

    // Incoming image packed so that img_c[i] is column i
    assign img_c = {bus.col_4, bus.col_3, bus.col_2, bus.col_1, bus.col_0};

    // Slot counter, column index, frame snapshot and next output values
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        fb_d          = fb_q;
        frame_start_d = 1'b0;
        col_drive_d   = COL_OFF;
        row_drive_d   = ROW_OFF;

        if (!bus.enable) begin
            // Rewind so the next enabled edge starts a fresh frame; fb holds
            cnt_d = '0;
            idx_d = '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if ((cnt_q == '0) && (idx_q == '0)) begin
                fb_d          = img_c;
                frame_start_d = 1'b1;
            end

            // Outputs follow the pre-edge position but the post-snapshot image
            if (cnt_q >= CNT_BLANK) begin
                col_drive_d = COL_OFF ^ (NUM_COLS'(1) << idx_q);
                row_drive_d = fb_d[idx_q] ^ ROW_OFF;
            end
        end
    end

    // State and output registers; reset forces outputs inactive at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            fb_q          <= '0;
            col_drive_q   <= COL_OFF;
            row_drive_q   <= ROW_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            fb_q          <= fb_d;
            col_drive_q   <= col_drive_d;
            row_drive_q   <= row_drive_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.col_drive   = col_drive_q;
    assign bus.row_drive   = row_drive_q;
    assign bus.frame_start = frame_start_q;

endmodule
